// File: rtl/npu_pkg.sv
// +----------------------------------------------------------------------+
// | npu_pkg : shared FSM state encoding and chunk-counter sizing helpers |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int c_max_chunks_def = 16;

  // One extra bit so the counter can hold MAX_CHUNKS itself.
  function automatic int calc_cw(input int max_chunks);
    return $clog2(max_chunks) + 1;
  endfunction

  localparam int CW = calc_cw(c_max_chunks_def);

endpackage

`default_nettype wire

// File: rtl/DotProduct.sv
// +----------------------------------------------------------------------+
// | DotProduct : combinational signed dot product of N packed elements   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module DotProduct
  import npu_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH + $clog2(N) + 1
) (
  input  logic [N*DATA_WIDTH-1:0] x,
  input  logic [N*DATA_WIDTH-1:0] w,
  output logic signed [OUT_WIDTH-1:0] dp
);

  logic signed [2*DATA_WIDTH-1:0] w_prod [N];

  for (genvar i = 0; i < N; i++) begin : g_prod
    logic signed [2*DATA_WIDTH-1:0] w_xe;
    logic signed [2*DATA_WIDTH-1:0] w_we;
    assign w_xe = {{DATA_WIDTH{x[i*DATA_WIDTH+DATA_WIDTH-1]}}, x[i*DATA_WIDTH +: DATA_WIDTH]};
    assign w_we = {{DATA_WIDTH{w[i*DATA_WIDTH+DATA_WIDTH-1]}}, w[i*DATA_WIDTH +: DATA_WIDTH]};
    assign w_prod[i] = w_xe * w_we;
  end

  always_comb begin
    dp = '0;
    for (int i = 0; i < N; i++) begin
      dp = dp + {{(OUT_WIDTH-2*DATA_WIDTH){w_prod[i][2*DATA_WIDTH-1]}}, w_prod[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/width.svh
// +----------------------------------------------------------------------+
// | width.svh : default element/accumulator widths for the NPU datapath  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none
`ifndef WIDTH_SVH
`define WIDTH_SVH

`ifndef N
`define N 4
`endif

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

`endif
`default_nettype wire

// File: rtl/dp_accum_sequencer.sv
// +----------------------------------------------------------------------+
// | dp_accum_sequencer : accumulates per-chunk dot products into a job   |
// | result; DP_ACCUM_SATURATE_EN selects saturating accumulation.        |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`include "width.svh"
`default_nettype none

module dp_accum_sequencer
  import npu_pkg::*;
#(
  parameter int N          = `N,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ACC_WIDTH  = `ACC_WIDTH,
  parameter int MAX_CHUNKS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [calc_cw(MAX_CHUNKS)-1:0]   num_chunks,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N*DATA_WIDTH-1:0]          x,
  input  logic [N*DATA_WIDTH-1:0]          w,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [ACC_WIDTH-1:0]      out_dp,
  output logic                             busy,
  output logic                             overflow
);

  localparam int CWL = calc_cw(MAX_CHUNKS);
  localparam int PW  = 2 * DATA_WIDTH + $clog2(N) + 1;
  localparam int SW  = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

  state_t                      r_state;
  state_t                      w_next;
  logic [CWL-1:0]              r_count;
  logic [CWL-1:0]              r_total;
  logic [CWL-1:0]              w_total_in;
  logic [CWL-1:0]              w_count_inc;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic signed [PW-1:0]        w_prod;
  logic signed [SW-1:0]        w_sum;
  logic                        w_take_start;
  logic                        w_take_chunk;

  DotProduct #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (PW)
  ) u_dot (
    .x  (x),
    .w  (w),
    .dp (w_prod)
  );

  assign w_total_in   = (num_chunks > CWL'(MAX_CHUNKS)) ? CWL'(MAX_CHUNKS) : num_chunks;
  assign w_count_inc  = r_count + CWL'(1);
  assign w_take_start = (r_state == ST_IDLE) && start;
  assign w_take_chunk = (r_state == ST_ACCUM) && in_valid;

  // Sum is formed one bit wider than either operand so it never wraps.
  assign w_sum = {{(SW-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc}
               + {{(SW-PW){w_prod[PW-1]}}, w_prod};

`ifdef DP_ACCUM_SATURATE_EN
  localparam logic signed [SW-1:0] c_acc_max = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] c_acc_min = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  logic w_hi;
  logic w_lo;
  logic r_ovf;

  assign w_hi = (w_sum > c_acc_max);
  assign w_lo = (w_sum < c_acc_min);

  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    if (w_hi) begin
      w_acc_next = c_acc_max[ACC_WIDTH-1:0];
    end else if (w_lo) begin
      w_acc_next = c_acc_min[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_take_start) begin
      r_ovf <= 1'b0;
    end else if (w_take_chunk && (w_hi || w_lo)) begin
      r_ovf <= 1'b1;
    end
  end

  assign overflow = r_ovf;
`else
  logic w_unused_sum;

  assign w_acc_next   = w_sum[ACC_WIDTH-1:0];
  assign w_unused_sum = ^w_sum[SW-1:ACC_WIDTH];
  assign overflow     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_total <= '0;
    end else if (w_take_start) begin
      r_acc   <= '0;
      r_count <= '0;
      r_total <= w_total_in;
    end else if (w_take_chunk) begin
      r_acc   <= w_acc_next;
      r_count <= w_count_inc;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (w_total_in == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (w_count_inc == r_total)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign out_dp = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_dp_accum_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_dp_accum_sequencer : directed scoreboard bench for the sequencer  |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dp_accum_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int CW = 5;

  typedef struct {
    int dp;
    int ovf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_chunks;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] x;
  logic [N*DW-1:0] w;
  logic          out_valid;
  logic          out_ready;
  logic signed [AW-1:0] out_dp;
  logic          busy;
  logic          overflow;

  exp_t sb[$];
  int   total;
  int   bad;

  dp_accum_sequencer #(
    .N          (N),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .MAX_CHUNKS (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_chunks (num_chunks),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .w          (w),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_dp     (out_dp),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    logic [31:0] r;
    r[7:0]   = a[7:0];
    r[15:8]  = b[7:0];
    r[23:16] = c[7:0];
    r[31:24] = d[7:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input int dp, input int ovf);
    exp_t e;
    e.dp  = dp;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic start_job(input int nc);
    start      = 1'b1;
    num_chunks = nc[CW-1:0];
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] xv, input logic [31:0] wv);
    int n;
    x        = xv;
    w        = wv;
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("return_idle", busy, 0);
  endtask

  // Scoreboard monitor: a result is consumed on the edge following this sample.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got out_dp=%0d expected no result", out_dp);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_out_dp", int'(out_dp), e.dp);
        check("sb_overflow", int'(overflow), e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_chunks = '0;
    in_valid   = 1'b0;
    x          = '0;
    w          = '0;
    out_ready  = 1'b1;

    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_dp", int'(out_dp), 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two chunks of {1,2,3,4}.{1,1,1,1} = 10 each
    start_job(2);
    expect_result(20, 0);
    send(pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    check("lat_early_valid", out_valid, 0);
    send(pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    check("lat_valid", out_valid, 1);
    check("lat_in_ready", in_ready, 0);
    wait_idle();

    // Zero-length job
    start_job(0);
    expect_result(0, 0);
    check("zero_valid", out_valid, 1);
    check("zero_in_ready", in_ready, 0);
    check("zero_busy", busy, 1);
    wait_idle();

    // Three chunks with gaps, result held under back-pressure: -60 - 100 + 16384
    out_ready = 1'b0;
    start_job(3);
    expect_result(16224, 0);
    send(pk(1, -2, 3, -4), pk(5, 6, -7, 8));
    for (int i = 0; i < 2; i++) begin
      check("gap_busy", busy, 1);
      check("gap_in_ready", in_ready, 1);
      tick();
    end
    send(pk(10, 20, 30, 40), pk(-1, -1, -1, -1));
    check("gap2_busy", busy, 1);
    tick();
    send(pk(-128, 0, 0, 0), pk(-128, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_dp", int'(out_dp), 16224);
      check("hold_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // Three chunks of 4*127*127 = 64516 each
    start_job(3);
`ifdef DP_ACCUM_SATURATE_EN
    expect_result(32767, 1);
`else
    expect_result(-3060, 0);
`endif
    for (int i = 0; i < 3; i++) send(pk(127, 127, 127, 127), pk(127, 127, 127, 127));
    wait_idle();

    // Overflow flag must clear on the next accepted start
    start_job(1);
    expect_result(10, 0);
    send(pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    wait_idle();

    // Asynchronous reset mid-job discards the partial result
    start_job(3);
    send(pk(1, 1, 1, 1), pk(3, 3, 3, 3));
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_dp", int'(out_dp), 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_job(1);
    expect_result(8, 0);
    send(pk(1, 1, 1, 1), pk(2, 2, 2, 2));
    wait_idle();

    // start held high through ACCUM and DONE
    out_ready  = 1'b0;
    start      = 1'b1;
    num_chunks = 5'd2;
    tick();
    num_chunks = 5'd0;
    expect_result(8, 0);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    for (int i = 0; i < 2; i++) begin
      check("held_start_valid", out_valid, 1);
      check("held_start_dp", int'(out_dp), 8);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("held_start_idle", busy, 0);
    expect_result(0, 0);
    tick();
    check("held_start_restart", out_valid, 1);
    start = 1'b0;
    wait_idle();

    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
